// File: rtl/ysyx_24090003_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_24090003_mem_arbiter
//
// Shares one memory port between the instruction fetch unit (IFU, read-only)
// and the load/store unit (LSU, read/write). Only one transaction is
// outstanding at a time. Each request is accepted by a valid/ready
// handshake. The owning master then gets a one-cycle response pulse. A
// response timeout forces an error response, so a stalled slave cannot
// hang the core.
//
// Configuration macro:
//   YSYX_24090003_ARB_RR_EN  defined   -> round-robin tie-break (last_owner)
//                            undefined -> fixed priority, LSU wins ties
//
// Parameter:
//   TIMEOUT_CYCLES  cycles spent in RSP without a response before an error
//                   response is forced (1..255)
//
// Ports:
//   i_clk, i_rst_n                  clock, async active-low reset
//   i_ifu_req_valid / o_ifu_req_ready / i_ifu_addr          IFU request
//   o_ifu_rsp_valid / o_ifu_rdata / o_ifu_rsp_err           IFU response
//   i_lsu_req_valid / o_lsu_req_ready / i_lsu_addr,
//   i_lsu_wen / i_lsu_wdata / i_lsu_wstrb                   LSU request
//   o_lsu_rsp_valid / o_lsu_rdata / o_lsu_rsp_err           LSU response
//   o_mem_req_valid / i_mem_req_ready / o_mem_addr,
//   o_mem_wen / o_mem_wdata / o_mem_wstrb                   memory request
//   i_mem_rsp_valid / i_mem_rdata / i_mem_rsp_err /
//   o_mem_rsp_ready                                         memory response
// ---------------------------------------------------------------------------
module ysyx_24090003_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ifu_req_valid,
    output logic        o_ifu_req_ready,
    input  logic [31:0] i_ifu_addr,
    output logic        o_ifu_rsp_valid,
    output logic [31:0] o_ifu_rdata,
    output logic        o_ifu_rsp_err,
    input  logic        i_lsu_req_valid,
    output logic        o_lsu_req_ready,
    input  logic [31:0] i_lsu_addr,
    input  logic        i_lsu_wen,
    input  logic [31:0] i_lsu_wdata,
    input  logic [3:0]  i_lsu_wstrb,
    output logic        o_lsu_rsp_valid,
    output logic [31:0] o_lsu_rdata,
    output logic        o_lsu_rsp_err,
    output logic        o_mem_req_valid,
    input  logic        i_mem_req_ready,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_wstrb,
    input  logic        i_mem_rsp_valid,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_rsp_err,
    output logic        o_mem_rsp_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    // The counter value that marks the last cycle a response is waited for.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    owner_t      owner;
    logic [31:0] addr_q;
    logic        wen_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [7:0]  cnt;

    logic        grant_ifu;
    logic        grant_lsu;
    logic        accept;
    logic        rsp_take;
    logic        rsp_timeout;

`ifdef YSYX_24090003_ARB_RR_EN
    owner_t      last_owner;

    // On a tie, the master that did not own the previous accept wins.
    assign grant_lsu = i_lsu_req_valid && (!i_ifu_req_valid || (last_owner == OWN_IFU));
`else
    assign grant_lsu = i_lsu_req_valid;
`endif
    assign grant_ifu = i_ifu_req_valid && !grant_lsu;

    // The latched request fields drive the memory port directly. They only
    // change at an accept, so they stay stable through REQ.
    assign o_mem_addr  = addr_q;
    assign o_mem_wen   = wen_q;
    assign o_mem_wdata = wdata_q;
    assign o_mem_wstrb = wstrb_q;

    always_comb begin
        // NOTE: every signal written here gets a default first. No path can
        // then leave a value held, which would infer a latch.
        state_nxt       = state;
        o_ifu_req_ready = 1'b0;
        o_lsu_req_ready = 1'b0;
        o_ifu_rsp_valid = 1'b0;
        o_ifu_rdata     = 32'h0;
        o_ifu_rsp_err   = 1'b0;
        o_lsu_rsp_valid = 1'b0;
        o_lsu_rdata     = 32'h0;
        o_lsu_rsp_err   = 1'b0;
        o_mem_req_valid = 1'b0;
        o_mem_rsp_ready = 1'b0;
        accept          = 1'b0;
        rsp_take        = 1'b0;
        rsp_timeout     = 1'b0;

        case (state)
            S_IDLE: begin
                o_ifu_req_ready = grant_ifu;
                o_lsu_req_ready = grant_lsu;
                accept          = grant_ifu || grant_lsu;
                if (accept) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                o_mem_req_valid = 1'b1;
                if (i_mem_req_ready) begin
                    state_nxt = S_RSP;
                end
            end
            S_RSP: begin
                o_mem_rsp_ready = 1'b1;
                // The response takes priority over a timeout in the same cycle.
                if (i_mem_rsp_valid) begin
                    rsp_take  = 1'b1;
                    state_nxt = S_RESP;
                end else if (cnt == CNT_LAST) begin
                    rsp_timeout = 1'b1;
                    state_nxt   = S_RESP;
                end
            end
            S_RESP: begin
                if (owner == OWN_LSU) begin
                    o_lsu_rsp_valid = 1'b1;
                    o_lsu_rdata     = rdata_q;
                    o_lsu_rsp_err   = err_q;
                end else begin
                    o_ifu_rsp_valid = 1'b1;
                    o_ifu_rdata     = rdata_q;
                    o_ifu_rsp_err   = err_q;
                end
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: state registers use non-blocking assignments. Every flop then
        // samples pre-edge values, whatever order the blocks are evaluated in.
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            owner   <= OWN_IFU;
            addr_q  <= 32'h0;
            wen_q   <= 1'b0;
            wdata_q <= 32'h0;
            wstrb_q <= 4'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            cnt     <= 8'h0;
        end else begin
            if (accept) begin
                // IFU requests carry no write fields, so they are latched as 0.
                owner   <= grant_lsu ? OWN_LSU : OWN_IFU;
                addr_q  <= grant_lsu ? i_lsu_addr : i_ifu_addr;
                wen_q   <= grant_lsu && i_lsu_wen;
                wdata_q <= grant_lsu ? i_lsu_wdata : 32'h0;
                wstrb_q <= grant_lsu ? i_lsu_wstrb : 4'h0;
            end

            if ((state == S_REQ) && i_mem_req_ready) begin
                cnt <= 8'h0;
            end else if ((state == S_RSP) && !i_mem_rsp_valid) begin
                cnt <= cnt + 8'd1;
            end

            if (rsp_take) begin
                rdata_q <= wen_q ? 32'h0 : i_mem_rdata;
                err_q   <= i_mem_rsp_err;
            end else if (rsp_timeout) begin
                rdata_q <= 32'h0;
                err_q   <= 1'b1;
            end
        end
    end

`ifdef YSYX_24090003_ARB_RR_EN
    // last_owner resets to LSU, so the first tie after reset grants IFU.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_owner <= OWN_LSU;
        end else if (accept) begin
            last_owner <= grant_lsu ? OWN_LSU : OWN_IFU;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_24090003_mem_arbiter.sv
// ---------------------------------------------------------------------------
// Self-checking bench for ysyx_24090003_mem_arbiter.
// Inputs are driven on the falling edge. Outputs are sampled 1 time unit
// later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_ysyx_24090003_mem_arbiter;

    localparam int TO = 4;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_ifu_req_valid;
    logic        o_ifu_req_ready;
    logic [31:0] i_ifu_addr;
    logic        o_ifu_rsp_valid;
    logic [31:0] o_ifu_rdata;
    logic        o_ifu_rsp_err;
    logic        i_lsu_req_valid;
    logic        o_lsu_req_ready;
    logic [31:0] i_lsu_addr;
    logic        i_lsu_wen;
    logic [31:0] i_lsu_wdata;
    logic [3:0]  i_lsu_wstrb;
    logic        o_lsu_rsp_valid;
    logic [31:0] o_lsu_rdata;
    logic        o_lsu_rsp_err;
    logic        o_mem_req_valid;
    logic        i_mem_req_ready;
    logic [31:0] o_mem_addr;
    logic        o_mem_wen;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_wstrb;
    logic        i_mem_rsp_valid;
    logic [31:0] i_mem_rdata;
    logic        i_mem_rsp_err;
    logic        o_mem_rsp_ready;

    ysyx_24090003_mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_ifu_req_valid (i_ifu_req_valid),
        .o_ifu_req_ready (o_ifu_req_ready),
        .i_ifu_addr      (i_ifu_addr),
        .o_ifu_rsp_valid (o_ifu_rsp_valid),
        .o_ifu_rdata     (o_ifu_rdata),
        .o_ifu_rsp_err   (o_ifu_rsp_err),
        .i_lsu_req_valid (i_lsu_req_valid),
        .o_lsu_req_ready (o_lsu_req_ready),
        .i_lsu_addr      (i_lsu_addr),
        .i_lsu_wen       (i_lsu_wen),
        .i_lsu_wdata     (i_lsu_wdata),
        .i_lsu_wstrb     (i_lsu_wstrb),
        .o_lsu_rsp_valid (o_lsu_rsp_valid),
        .o_lsu_rdata     (o_lsu_rdata),
        .o_lsu_rsp_err   (o_lsu_rsp_err),
        .o_mem_req_valid (o_mem_req_valid),
        .i_mem_req_ready (i_mem_req_ready),
        .o_mem_addr      (o_mem_addr),
        .o_mem_wen       (o_mem_wen),
        .o_mem_wdata     (o_mem_wdata),
        .o_mem_wstrb     (o_mem_wstrb),
        .i_mem_rsp_valid (i_mem_rsp_valid),
        .i_mem_rdata     (i_mem_rdata),
        .i_mem_rsp_err   (i_mem_rsp_err),
        .o_mem_rsp_ready (o_mem_rsp_ready)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: did the LSU own the most recent accept?
    logic model_last_lsu = 1'b1;

    typedef struct {
        logic        ifu_v;
        logic        lsu_v;
        logic [31:0] ifu_addr;
        logic [31:0] lsu_addr;
        logic        lsu_wen;
        logic [31:0] lsu_wdata;
        logic [3:0]  lsu_wstrb;
        int          req_wait;   // cycles i_mem_req_ready is held low
        int          rsp_wait;   // cycles before response (>= TO: none)
        logic [31:0] mdata;
        logic        merr;
        logic        exp_lsu;    // expected owner
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic lv, input logic [31:0] ia,
                                input logic [31:0] la, input logic wen, input logic [31:0] wd,
                                input logic [3:0] ws, input int rqw, input int rsw,
                                input logic [31:0] md, input logic me, input logic el,
                                input logic [31:0] erd, input logic eer);
        vec_t v;
        v.ifu_v = iv;  v.lsu_v = lv;  v.ifu_addr = ia; v.lsu_addr = la;
        v.lsu_wen = wen; v.lsu_wdata = wd; v.lsu_wstrb = ws;
        v.req_wait = rqw; v.rsp_wait = rsw; v.mdata = md; v.merr = me;
        v.exp_lsu = el; v.exp_rdata = erd; v.exp_err = eer;
        return v;
    endfunction

    // Arbitration rule: a lone requester wins. A tie goes to LSU (fixed),
    // or to whichever master did not win last time (round-robin).
    function automatic logic model_grant_lsu(input logic iv, input logic lv);
        if (!lv) return 1'b0;
        if (!iv) return 1'b1;
`ifdef YSYX_24090003_ARB_RR_EN
        return !model_last_lsu;
`else
        return 1'b1;
`endif
    endfunction

    // Fills in the expected owner and response from the request and the
    // slave behaviour.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.exp_lsu = model_grant_lsu(v.ifu_v, v.lsu_v);
        if (v.rsp_wait >= TO) begin
            r.exp_rdata = 32'h0;
            r.exp_err   = 1'b1;
        end else begin
            r.exp_rdata = (r.exp_lsu && v.lsu_wen) ? 32'h0 : v.mdata;
            r.exp_err   = v.merr;
        end
        return r;
    endfunction

    // Runs one complete transaction. It starts and ends just after a
    // falling edge, with the DUT in IDLE.
    task automatic do_txn(input vec_t v);
        logic [31:0] e_addr;
        logic        e_wen;
        logic [31:0] e_wdata;
        logic [3:0]  e_wstrb;
        int          k;
        e_addr  = v.exp_lsu ? v.lsu_addr : v.ifu_addr;
        e_wen   = v.exp_lsu && v.lsu_wen;
        e_wdata = v.exp_lsu ? v.lsu_wdata : 32'h0;
        e_wstrb = v.exp_lsu ? v.lsu_wstrb : 4'h0;

        i_ifu_req_valid = v.ifu_v;
        i_lsu_req_valid = v.lsu_v;
        i_ifu_addr      = v.ifu_addr;
        i_lsu_addr      = v.lsu_addr;
        i_lsu_wen       = v.lsu_wen;
        i_lsu_wdata     = v.lsu_wdata;
        i_lsu_wstrb     = v.lsu_wstrb;
        #1;
        check("ifu_req_ready", 32'(o_ifu_req_ready), 32'(!v.exp_lsu));
        check("lsu_req_ready", 32'(o_lsu_req_ready), 32'(v.exp_lsu));
        @(posedge i_clk);
        model_last_lsu = v.exp_lsu;
        @(negedge i_clk);
        // Request inputs change after the handshake and must have no effect.
        i_ifu_req_valid = 1'b0;
        i_lsu_req_valid = 1'b0;
        i_ifu_addr      = $urandom;
        i_lsu_addr      = $urandom;
        i_lsu_wen       = 1'($urandom);
        i_lsu_wdata     = $urandom;
        i_lsu_wstrb     = 4'($urandom);

        for (int i = 0; i <= v.req_wait; i++) begin
            i_mem_req_ready = (i == v.req_wait);
            #1;
            check("mem_req_valid", 32'(o_mem_req_valid), 32'd1);
            check("mem_addr", o_mem_addr, e_addr);
            check("mem_wen", 32'(o_mem_wen), 32'(e_wen));
            check("mem_wdata", o_mem_wdata, e_wdata);
            check("mem_wstrb", 32'(o_mem_wstrb), 32'(e_wstrb));
            check("mem_rsp_ready_in_req", 32'(o_mem_rsp_ready), 32'd0);
            @(negedge i_clk);
        end
        i_mem_req_ready = 1'b0;

        k = 0;
        while (k < v.rsp_wait && k < TO) begin
            i_mem_rsp_valid = 1'b0;
            i_mem_rdata     = $urandom;
            #1;
            check("mem_rsp_ready", 32'(o_mem_rsp_ready), 32'd1);
            check("mem_req_valid_in_rsp", 32'(o_mem_req_valid), 32'd0);
            @(negedge i_clk);
            k++;
        end
        if (v.rsp_wait < TO) begin
            i_mem_rsp_valid = 1'b1;
            i_mem_rdata     = v.mdata;
            i_mem_rsp_err   = v.merr;
            #1;
            check("mem_rsp_ready", 32'(o_mem_rsp_ready), 32'd1);
            @(negedge i_clk);
            i_mem_rsp_valid = 1'b0;
            i_mem_rsp_err   = 1'b0;
        end

        #1;
        check("ifu_rsp_valid", 32'(o_ifu_rsp_valid), 32'(!v.exp_lsu));
        check("lsu_rsp_valid", 32'(o_lsu_rsp_valid), 32'(v.exp_lsu));
        check("ifu_rdata", o_ifu_rdata, v.exp_lsu ? 32'h0 : v.exp_rdata);
        check("ifu_rsp_err", 32'(o_ifu_rsp_err), v.exp_lsu ? 32'd0 : 32'(v.exp_err));
        check("lsu_rdata", o_lsu_rdata, v.exp_lsu ? v.exp_rdata : 32'h0);
        check("lsu_rsp_err", 32'(o_lsu_rsp_err), v.exp_lsu ? 32'(v.exp_err) : 32'd0);
        check("mem_rsp_ready_in_resp", 32'(o_mem_rsp_ready), 32'd0);
        @(negedge i_clk);
        #1;
        check("ifu_rsp_pulse_end", 32'(o_ifu_rsp_valid), 32'd0);
        check("lsu_rsp_pulse_end", 32'(o_lsu_rsp_valid), 32'd0);
        check("mem_req_valid_idle", 32'(o_mem_req_valid), 32'd0);
    endtask

    vec_t tbl[7];
    vec_t v;

    initial begin
        tbl[0] = mk(1, 0, 32'h8000_0000, 32'h0, 0, 32'h0, 4'h0, 0, 0,
                    32'h0000_0413, 0, 0, 32'h0000_0413, 0);
        tbl[1] = mk(0, 1, 32'h0, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'hF, 3, 0,
                    32'h1234_5678, 0, 1, 32'h0, 0);
        tbl[2] = mk(0, 1, 32'h0, 32'h8000_2000, 0, 32'h0, 4'hF, 0, 1,
                    32'hCAFE_F00D, 1, 1, 32'hCAFE_F00D, 1);
        tbl[3] = mk(1, 0, 32'h8000_0010, 32'h0, 0, 32'h0, 4'h0, 1, 10,
                    32'h5555_5555, 0, 0, 32'h0, 1);
        tbl[4] = mk(1, 0, 32'h8000_0020, 32'h0, 0, 32'h0, 4'h0, 0, TO - 1,
                    32'hA5A5_A5A5, 0, 0, 32'hA5A5_A5A5, 0);
        tbl[5] = mk(0, 1, 32'h0, 32'h8000_3000, 1, 32'h0BAD_F00D, 4'h3, 0, TO,
                    32'h7777_7777, 0, 1, 32'h0, 1);
        tbl[6] = mk(0, 1, 32'h0, 32'h8000_3004, 1, 32'h1111_2222, 4'hC, 2, 2,
                    32'h9999_9999, 1, 1, 32'h0, 1);

        i_rst_n = 1'b0;
        i_ifu_req_valid = 1'b0; i_ifu_addr = 32'h0;
        i_lsu_req_valid = 1'b0; i_lsu_addr = 32'h0; i_lsu_wen = 1'b0;
        i_lsu_wdata = 32'h0; i_lsu_wstrb = 4'h0;
        i_mem_req_ready = 1'b0; i_mem_rsp_valid = 1'b0;
        i_mem_rdata = 32'h0; i_mem_rsp_err = 1'b0;
        #12;
        check("rst_mem_req_valid", 32'(o_mem_req_valid), 32'd0);
        check("rst_mem_rsp_ready", 32'(o_mem_rsp_ready), 32'd0);
        check("rst_mem_addr", o_mem_addr, 32'h0);
        check("rst_mem_wen", 32'(o_mem_wen), 32'd0);
        check("rst_ifu_rsp_valid", 32'(o_ifu_rsp_valid), 32'd0);
        check("rst_lsu_rsp_valid", 32'(o_lsu_rsp_valid), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        model_last_lsu = 1'b1;
        #1;
        check("idle_no_req_ifu_ready", 32'(o_ifu_req_ready), 32'd0);
        check("idle_no_req_lsu_ready", 32'(o_lsu_req_ready), 32'd0);

        // Two ties in a row right after reset, then the IFU on its own.
        for (int i = 0; i < 2; i++) begin
            v = model(mk(1, 1, 32'h8000_0100 + 32'(i), 32'h8000_0200 + 32'(i), 0,
                         32'h0, 4'hF, 0, 0, 32'h3000_0000 + 32'(i), 0, 0, 32'h0, 0));
`ifdef YSYX_24090003_ARB_RR_EN
            check("tie_owner_rr", 32'(v.exp_lsu), 32'(i == 1));
`else
            check("tie_owner_fixed", 32'(v.exp_lsu), 32'd1);
`endif
            do_txn(v);
        end
        do_txn(model(mk(1, 0, 32'h8000_0300, 32'h0, 0, 32'h0, 4'h0, 0, 0,
                        32'h4444_0000, 0, 0, 32'h0, 0)));

        for (int i = 0; i < 7; i++) begin
            do_txn(tbl[i]);
            model_last_lsu = tbl[i].exp_lsu;
        end

        // A response that arrives after a timeout, while IDLE, is discarded.
        do_txn(tbl[3]);
        for (int i = 0; i < 2; i++) begin
            i_mem_rsp_valid = 1'b1;
            i_mem_rdata     = 32'h1111_1111;
            #1;
            check("late_rsp_ready", 32'(o_mem_rsp_ready), 32'd0);
            @(negedge i_clk);
            #1;
            check("late_rsp_ifu", 32'(o_ifu_rsp_valid), 32'd0);
            check("late_rsp_lsu", 32'(o_lsu_rsp_valid), 32'd0);
        end
        i_mem_rsp_valid = 1'b0;

        for (int n = 0; n < 40; n++) begin
            v.ifu_v     = 1'($urandom_range(0, 1));
            v.lsu_v     = 1'($urandom_range(0, 1));
            if (!v.ifu_v && !v.lsu_v) v.ifu_v = 1'b1;
            v.ifu_addr  = $urandom;
            v.lsu_addr  = $urandom;
            v.lsu_wen   = 1'($urandom_range(0, 1));
            v.lsu_wdata = $urandom;
            v.lsu_wstrb = 4'($urandom);
            v.req_wait  = int'($urandom_range(0, 2));
            v.rsp_wait  = int'($urandom_range(0, TO + 1));
            v.mdata     = $urandom;
            v.merr      = 1'($urandom_range(0, 1));
            do_txn(model(v));
        end

        // Asynchronous reset while waiting in RSP.
        i_ifu_req_valid = 1'b1;
        i_ifu_addr      = 32'h8000_4000;
        #1;
        check("pre_rst_ifu_ready", 32'(o_ifu_req_ready), 32'd1);
        @(negedge i_clk);
        i_ifu_req_valid = 1'b0;
        i_mem_req_ready = 1'b1;
        @(negedge i_clk);
        i_mem_req_ready = 1'b0;
        #1;
        check("pre_rst_rsp_ready", 32'(o_mem_rsp_ready), 32'd1);
        #1;
        i_rst_n = 1'b0;
        #1;
        check("async_rst_rsp_ready", 32'(o_mem_rsp_ready), 32'd0);
        check("async_rst_mem_addr", o_mem_addr, 32'h0);
        check("async_rst_req_valid", 32'(o_mem_req_valid), 32'd0);
        check("async_rst_ifu_rsp", 32'(o_ifu_rsp_valid), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        model_last_lsu = 1'b1;
        for (int i = 0; i < 2; i++) begin
            i_mem_rsp_valid = 1'b1;
            i_mem_rdata     = 32'h2222_2222;
            #1;
            check("post_rst_rsp_ready", 32'(o_mem_rsp_ready), 32'd0);
            check("post_rst_ifu_rsp", 32'(o_ifu_rsp_valid), 32'd0);
            check("post_rst_lsu_rsp", 32'(o_lsu_rsp_valid), 32'd0);
            @(negedge i_clk);
        end
        i_mem_rsp_valid = 1'b0;
        do_txn(model(mk(1, 0, 32'h8000_5000, 32'h0, 0, 32'h0, 4'h0, 0, 0,
                        32'h0000_0013, 0, 0, 32'h0, 0)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
